// File: rtl/avalon_port_arbiter.sv
// Purpose: shares one Avalon-MM DDR port between two single-beat requesters (m0, m1) with round-robin grant.
// Latency: command on avl_* one cycle after grant, mN_ack one cycle after acceptance, read data one cycle after avl_readdatavalid.
// Backpressure: avl_waitrequest_n=0 holds the command; reads stall in arbitration while MAX_PEND reads are outstanding.
module avalon_port_arbiter #(
    parameter int ADDR_W   = 27,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 8
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              local_init_done,

    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readvalid,

    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readvalid,

    output logic [ADDR_W-1:0] avl_address,
    output logic [DATA_W-1:0] avl_writedata,
    output logic              avl_write,
    output logic              avl_read,
    output logic              avl_burstbegin,
    input  logic              avl_waitrequest_n,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_readdatavalid,

    output logic              rd_err
);

    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] PEND_LIMIT = CNT_W'(MAX_PEND);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // Arbitration bookkeeping: last_grant drives the tie-break, owner is the port of the transfer in flight.
    logic               last_grant;
    logic               owner;

    // Owner-tag FIFO: one bit per outstanding read (0 = m0, 1 = m1). pend_cnt doubles as its occupancy.
    logic [MAX_PEND-1:0] tag_mem;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   pend_cnt;

    // Registered read return shared by both ports; readvalid steers it.
    logic [DATA_W-1:0]  rd_data;

    logic               pend_room;
    logic               elig0;
    logic               elig1;
    logic               gnt_vld;
    logic               gnt_id;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_address;
    logic [DATA_W-1:0]  sel_writedata;
    logic               cmd_accept;
    logic               tag_push;
    logic               tag_pop;
    logic               tag_empty;
    logic               pop_tag;

    assign pend_room  = (pend_cnt < PEND_LIMIT);
    assign tag_empty  = (pend_cnt == '0);
    assign cmd_accept = (state == CMD) && avl_waitrequest_n;
    assign tag_push   = cmd_accept && avl_read;
    assign tag_pop    = avl_readdatavalid && !tag_empty;
    assign pop_tag    = tag_mem[rd_ptr];

    assign avl_burstbegin = avl_write | avl_read;
    assign m0_readdata    = rd_data;
    assign m1_readdata    = rd_data;

    // Eligibility: calibration must be done; reads also need a free tag slot, writes never wait on reads.
    always_comb begin
        elig0 = m0_req && local_init_done && (m0_write || pend_room);
        elig1 = m1_req && local_init_done && (m1_write || pend_room);
    end

    // Round-robin pick: a lone eligible port wins, a tie goes to the port that did not win last time.
    always_comb begin
        gnt_vld = elig0 || elig1;
        gnt_id  = 1'b0;
        if (elig0 && elig1) begin
            gnt_id = ~last_grant;
        end else if (elig1) begin
            gnt_id = 1'b1;
        end
    end

    // Command source mux for the granted port.
    always_comb begin
        sel_write     = m0_write;
        sel_address   = m0_address;
        sel_writedata = m0_writedata;
        if (gnt_id) begin
            sel_write     = m1_write;
            sel_address   = m1_address;
            sel_writedata = m1_writedata;
        end
    end

    // State register.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant in IDLE, wait out waitrequest in CMD, spend exactly one cycle in ACK.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (gnt_vld) state_nxt = CMD;
            CMD:  if (avl_waitrequest_n) state_nxt = ACK;
            ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command registers: loaded on grant, held through waitrequest, dropped on acceptance.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            avl_address   <= '0;
            avl_writedata <= '0;
            avl_write     <= 1'b0;
            avl_read      <= 1'b0;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
        end else begin
            if ((state == IDLE) && gnt_vld) begin
                avl_address   <= sel_address;
                avl_writedata <= sel_writedata;
                avl_write     <= sel_write;
                avl_read      <= ~sel_write;
                owner         <= gnt_id;
                last_grant    <= gnt_id;
            end else if (cmd_accept) begin
                avl_write <= 1'b0;
                avl_read  <= 1'b0;
            end
        end
    end

    // Acknowledge pulses: high during the ACK cycle for the owning port only.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
        end else begin
            m0_ack <= cmd_accept && !owner;
            m1_ack <= cmd_accept && owner;
        end
    end

    // Tag FIFO storage and pointers; pointers wrap naturally because MAX_PEND is a power of two.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (tag_push) begin
                tag_mem[wr_ptr] <= owner;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (tag_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Outstanding-read count: push and pop in the same cycle cancel out.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pend_cnt <= '0;
        end else begin
            unique case ({tag_push, tag_pop})
                2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
                2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // Read return: route popped data to the tagged owner one cycle later; data with no tag is dropped and flagged.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rd_data      <= '0;
            m0_readvalid <= 1'b0;
            m1_readvalid <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            m0_readvalid <= tag_pop && !pop_tag;
            m1_readvalid <= tag_pop && pop_tag;
            if (tag_pop) begin
                rd_data <= avl_readdata;
            end
            if (avl_readdatavalid && tag_empty) begin
                rd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_port_arbiter.sv
module tb_avalon_port_arbiter;

    localparam int ADDR_W   = 27;
    localparam int DATA_W   = 32;
    localparam int MAX_PEND = 2;

    logic              iCLK = 1'b0;
    logic              iRST_n = 1'b0;
    logic              local_init_done = 1'b0;
    logic              m0_req = 1'b0, m0_write = 1'b0;
    logic [ADDR_W-1:0] m0_address = '0;
    logic [DATA_W-1:0] m0_writedata = '0;
    logic              m1_req = 1'b0, m1_write = 1'b0;
    logic [ADDR_W-1:0] m1_address = '0;
    logic [DATA_W-1:0] m1_writedata = '0;
    logic              m0_ack, m1_ack, m0_readvalid, m1_readvalid;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic [ADDR_W-1:0] avl_address;
    logic [DATA_W-1:0] avl_writedata;
    logic              avl_write, avl_read, avl_burstbegin;
    logic              avl_waitrequest_n = 1'b1;
    logic [DATA_W-1:0] avl_readdata = '0;
    logic              avl_readdatavalid = 1'b0;
    logic              rd_err;

    avalon_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .local_init_done(local_init_done),
        .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_writedata(m0_writedata),
        .m0_ack(m0_ack), .m0_readdata(m0_readdata), .m0_readvalid(m0_readvalid),
        .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
        .m1_ack(m1_ack), .m1_readdata(m1_readdata), .m1_readvalid(m1_readvalid),
        .avl_address(avl_address), .avl_writedata(avl_writedata), .avl_write(avl_write),
        .avl_read(avl_read), .avl_burstbegin(avl_burstbegin), .avl_waitrequest_n(avl_waitrequest_n),
        .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid), .rd_err(rd_err)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int                owner;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t              cmd_q[$];
    logic [DATA_W-1:0] rd0_q[$];
    logic [DATA_W-1:0] rd1_q[$];
    logic [DATA_W-1:0] ret_q[$];
    int                due_q[$];

    int total = 0, bad = 0;
    int cyc = 0;
    int wait_cycles = 0, hold_m = 0;
    bit auto_ret = 1'b1;
    bit man_rdv = 1'b0;
    logic [DATA_W-1:0] man_data = '0;
    int rdv_cyc = 0;
    int ack_owner = -1, hold_len = 0, last_len = 0, acc_cnt = 0, acc_cyc = 0;
    int n0 = 0, t0 = 0, nw = 0;
    bit seen = 1'b0, drv_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got 0x%0h, required none", name, act);
    endtask

    function automatic cmd_t mk(input int o, input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_t c;
        c.owner = o; c.wr = w; c.addr = a; c.data = d;
        return c;
    endfunction

    // One requester transfer: caller is one step after a rising edge; request stays up until ack is seen.
    task automatic xfer(input int p, input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        if (p == 0) begin m0_req = 1; m0_write = w; m0_address = a; m0_writedata = d; end
        else        begin m1_req = 1; m1_write = w; m1_address = a; m1_writedata = d; end
        do begin
            @(negedge iCLK);
            n++;
        end while (!((p == 0) ? m0_ack : m1_ack) && n < 200);
        if (n >= 200) fail("xfer_timeout", a);
        @(posedge iCLK); #1;
        if (p == 0) m0_req = 0; else m1_req = 0;
    endtask

    // Controller model: waitrequest stretching, fixed 5-cycle read return, one-shot manual readdatavalid.
    always begin
        @(posedge iCLK);
        cyc++;
        #1;
        if (avl_write || avl_read) begin
            avl_waitrequest_n = (hold_m >= wait_cycles);
            if (avl_waitrequest_n) hold_m = 0; else hold_m++;
        end else begin
            hold_m = 0;
            avl_waitrequest_n = 1'b1;
        end
        avl_readdatavalid = 1'b0;
        if (man_rdv) begin
            avl_readdatavalid = 1'b1;
            avl_readdata = man_data;
            man_rdv = 1'b0;
            rdv_cyc = cyc;
        end else if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            avl_readdatavalid = 1'b1;
            avl_readdata = (ret_q.size() > 0) ? ret_q.pop_front() : '0;
        end
    end

    // Monitor: compares accepted commands, ack pulses and returned read data against the scoreboard queues.
    always @(negedge iCLK) begin
        cmd_t e;
        if (!iRST_n) begin
            ack_owner = -1;
            hold_len = 0;
        end else begin
            if (ack_owner >= 0) begin
                check("ack_owner", {m0_ack, m1_ack}, (ack_owner == 0) ? 2'b10 : 2'b01);
            end else if (m0_ack || m1_ack) begin
                fail("spurious_ack", {m0_ack, m1_ack});
            end
            ack_owner = -1;
            if (avl_write || avl_read) hold_len++;
            if ((avl_write || avl_read) && avl_waitrequest_n) begin
                last_len = hold_len;
                hold_len = 0;
                acc_cnt++;
                acc_cyc = cyc;
                if (cmd_q.size() == 0) begin
                    fail("unexpected_cmd", avl_address);
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_kind", {avl_write, avl_read, avl_burstbegin}, {e.wr, !e.wr, 1'b1});
                    check("cmd_addr", avl_address, e.addr);
                    if (e.wr) check("cmd_data", avl_writedata, e.data);
                    ack_owner = e.owner;
                    if (!e.wr && auto_ret) due_q.push_back(cyc + 5);
                end
            end
            if (m0_readvalid) begin
                if (rd0_q.size() == 0) fail("unexpected_m0_readvalid", m0_readdata);
                else check("m0_readdata", m0_readdata, rd0_q.pop_front());
            end
            if (m1_readvalid) begin
                if (rd1_q.size() == 0) fail("unexpected_m1_readvalid", m1_readdata);
                else check("m1_readdata", m1_readdata, rd1_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random requester inputs: every output must stay 0.
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge iCLK); #1;
            m0_req = 1'($urandom); m0_write = 1'($urandom); m0_address = ADDR_W'($urandom);
            m0_writedata = $urandom; m1_req = 1'($urandom); m1_write = 1'($urandom);
            m1_address = ADDR_W'($urandom); m1_writedata = $urandom; local_init_done = 1'($urandom);
            @(negedge iCLK);
            if ({avl_address, avl_writedata, avl_write, avl_read, avl_burstbegin, m0_ack, m1_ack,
                 m0_readvalid, m1_readvalid, m0_readdata, m1_readdata, rd_err} != '0) seen = 1;
        end
        check("reset_outputs_zero", seen, 0);
        m0_req = 0; m1_req = 0; local_init_done = 1;
        @(negedge iCLK); iRST_n = 1;
        seen = 0;
        repeat (5) begin @(negedge iCLK); if (avl_write || avl_read) seen = 1; end
        check("idle_after_reset", seen, 0);

        // Contention: both ports stream writes; order must alternate starting with m0.
        cmd_q.push_back(mk(0, 1, 27'h1000, 32'h11110000));
        cmd_q.push_back(mk(1, 1, 27'h2000, 32'h22220000));
        cmd_q.push_back(mk(0, 1, 27'h1004, 32'h11110001));
        cmd_q.push_back(mk(1, 1, 27'h2004, 32'h22220001));
        n0 = acc_cnt;
        @(posedge iCLK); #1;
        fork
            begin xfer(0, 1, 27'h1000, 32'h11110000); xfer(0, 1, 27'h1004, 32'h11110001); end
            begin xfer(1, 1, 27'h2000, 32'h22220000); xfer(1, 1, 27'h2004, 32'h22220001); end
        join
        check("contention_count", acc_cnt - n0, 4);

        // Single write stretched by 3 waitrequest cycles: command visible for 4 cycles.
        wait_cycles = 3;
        cmd_q.push_back(mk(0, 1, 27'h100, 32'h0055AA55));
        xfer(0, 1, 27'h100, 32'h0055AA55);
        check("write_hold_cycles", last_len, 4);
        wait_cycles = 0;

        // Read routing: m1 reads with an m0 write in between; data must come back to m1 only, in order.
        auto_ret = 1;
        for (int i = 0; i < 4; i++) begin
            ret_q.push_back(32'hA0 + i);
            rd1_q.push_back(32'hA0 + i);
        end
        cmd_q.push_back(mk(1, 0, 27'h10, '0));
        cmd_q.push_back(mk(1, 0, 27'h11, '0));
        cmd_q.push_back(mk(0, 1, 27'h200, 32'hCAFE0001));
        cmd_q.push_back(mk(1, 0, 27'h12, '0));
        cmd_q.push_back(mk(1, 0, 27'h13, '0));
        xfer(1, 0, 27'h10, '0);
        xfer(1, 0, 27'h11, '0);
        xfer(0, 1, 27'h200, 32'hCAFE0001);
        xfer(1, 0, 27'h12, '0);
        xfer(1, 0, 27'h13, '0);
        nw = 0;
        while (rd1_q.size() > 0 && nw < 50) begin @(negedge iCLK); nw++; end
        check("m1_reads_returned", rd1_q.size(), 0);

        // Back-pressure: with two reads outstanding the third m0 read waits, m1 write still proceeds.
        auto_ret = 0;
        cmd_q.push_back(mk(0, 0, 27'h300, '0));
        cmd_q.push_back(mk(0, 0, 27'h304, '0));
        cmd_q.push_back(mk(1, 1, 27'h400, 32'h12345678));
        cmd_q.push_back(mk(0, 0, 27'h308, '0));
        rd0_q.push_back(32'hB0); rd0_q.push_back(32'hB1); rd0_q.push_back(32'hB2);
        @(posedge iCLK); #1;
        n0 = acc_cnt;
        drv_done = 0;
        fork
            begin
                xfer(0, 0, 27'h300, '0); xfer(0, 0, 27'h304, '0); xfer(0, 0, 27'h308, '0);
                drv_done = 1;
            end
        join_none
        repeat (12) @(posedge iCLK);
        #1;
        check("bp_third_read_held", acc_cnt - n0, 2);
        xfer(1, 1, 27'h400, 32'h12345678);
        repeat (3) @(posedge iCLK);
        #1;
        check("bp_write_passes", acc_cnt - n0, 3);
        @(negedge iCLK); man_data = 32'hB0; man_rdv = 1;
        nw = 0;
        while (acc_cnt - n0 < 4 && nw < 20) begin @(negedge iCLK); nw++; end
        check("bp_third_read_issued", acc_cnt - n0, 4);
        check("bp_issue_after_free", (acc_cyc > rdv_cyc) && (acc_cyc <= rdv_cyc + 2), 1);
        nw = 0;
        while (!drv_done && nw < 50) begin @(negedge iCLK); nw++; end
        check("bp_driver_done", drv_done, 1);
        @(negedge iCLK); man_data = 32'hB1; man_rdv = 1;
        repeat (3) @(negedge iCLK);
        man_data = 32'hB2; man_rdv = 1;
        repeat (3) @(negedge iCLK);
        check("m0_reads_returned", rd0_q.size(), 0);

        // Calibration gate: no command while local_init_done is low, command the cycle after it rises.
        local_init_done = 0;
        cmd_q.push_back(mk(0, 1, 27'h500, 32'hDEAD0500));
        @(posedge iCLK); #1;
        drv_done = 0;
        n0 = acc_cnt;
        fork
            begin xfer(0, 1, 27'h500, 32'hDEAD0500); drv_done = 1; end
        join_none
        seen = 0;
        repeat (20) begin @(negedge iCLK); if (avl_write || avl_read) seen = 1; end
        check("init_gate_holds", seen, 0);
        @(posedge iCLK); #1;
        local_init_done = 1;
        t0 = cyc;
        nw = 0;
        while (acc_cnt == n0 && nw < 20) begin @(negedge iCLK); nw++; end
        check("init_issue_cycle", acc_cyc, t0 + 1);
        nw = 0;
        while (!drv_done && nw < 20) begin @(negedge iCLK); nw++; end

        // Stray read data with nothing outstanding: flagged, never delivered.
        check("rd_err_clear", rd_err, 0);
        @(negedge iCLK); man_data = 32'hEE; man_rdv = 1;
        repeat (3) @(negedge iCLK);
        check("rd_err_set", rd_err, 1);
        repeat (2) @(negedge iCLK);
        check("rd_err_sticky", rd_err, 1);

        // Reset during a stalled command: command drops at once, no ack, sticky error cleared.
        wait_cycles = 50;
        @(posedge iCLK); #1;
        m0_req = 1; m0_write = 1; m0_address = 27'h600; m0_writedata = 32'h66666666;
        nw = 0;
        do begin @(negedge iCLK); nw++; end while (!avl_write && nw < 10);
        check("midrst_cmd_up", avl_write, 1);
        iRST_n = 0;
        #1;
        check("midrst_cmd_drop", {avl_write, avl_read, avl_burstbegin, m0_ack, m1_ack}, 0);
        m0_req = 0;
        wait_cycles = 0;
        repeat (2) @(negedge iCLK);
        iRST_n = 1;
        check("midrst_rd_err_cleared", rd_err, 0);
        cmd_q.push_back(mk(1, 1, 27'h700, 32'h77770007));
        @(posedge iCLK); #1;
        xfer(1, 1, 27'h700, 32'h77770007);
        repeat (4) @(negedge iCLK);
        check("all_cmds_seen", cmd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
